// File: rtl/sw_pkg.sv
// sw_pkg: shared SW sizing, base encoding and loader state definitions
package sw_pkg;
  localparam int REF_MAX_LENGTH = 128;
  localparam int READ_MAX_LENGTH = 128;
  localparam int DP_SW_SCORE_BITWIDTH = 10;
  typedef enum logic [1:0] {BASE_A = 2'd0, BASE_C = 2'd1, BASE_G = 2'd2, BASE_T = 2'd3} base_t;
  typedef enum logic [2:0] {S_REF_LEN, S_READ_LEN, S_REF_DATA, S_READ_DATA, S_ISSUE} ld_state_t;
  function automatic int ceil4(input int n);
    return (n + 3) / 4;
  endfunction
endpackage

// File: rtl/sw_base_mask.sv
// sw_base_mask: zeroes the 2-bit lanes of one packed byte whose base index is >= len
module sw_base_mask #(
  parameter int IW = 6,
  parameter int LW = 8
) (
  input  logic [7:0]    byte_i,
  input  logic [IW-1:0] idx_i,
  input  logic [LW-1:0] len_i,
  output logic [7:0]    byte_o
);
  always_comb begin
    byte_o = byte_i;
    for (int j = 0; j < 4; j++)
      if (4 * int'(idx_i) + j >= int'(len_i)) byte_o[7-2*j -: 2] = 2'b00;
  end
endmodule

// File: rtl/sw_seq_loader.sv
// sw_seq_loader: assembles a framed byte stream into one packed SW_core job
module sw_seq_loader #(
  parameter int REF_MAX_LENGTH = sw_pkg::REF_MAX_LENGTH,
  parameter int READ_MAX_LENGTH = sw_pkg::READ_MAX_LENGTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_byte_valid,
  input  logic [7:0]                       i_byte,
  output logic                             o_byte_ready,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic [2*REF_MAX_LENGTH-1:0]      o_sequence_ref,
  output logic [2*READ_MAX_LENGTH-1:0]     o_sequence_read,
  output logic [$clog2(REF_MAX_LENGTH):0]  o_seq_ref_length,
  output logic [$clog2(READ_MAX_LENGTH):0] o_seq_read_length,
  output logic                             o_err
);
  import sw_pkg::*;
  localparam int FL = $clog2(REF_MAX_LENGTH) + 1;
  localparam int DL = $clog2(READ_MAX_LENGTH) + 1;
  localparam int ML = FL > DL ? FL : DL;
  localparam int CW = $clog2((REF_MAX_LENGTH > READ_MAX_LENGTH ? REF_MAX_LENGTH : READ_MAX_LENGTH) / 4) + 1;
  ld_state_t                   state_q;
  logic [FL-1:0]               ref_len_q;
  logic [DL-1:0]               read_len_q;
  logic [CW-1:0]               cnt_q;
  logic [2*REF_MAX_LENGTH-1:0] ref_q;
  logic [2*READ_MAX_LENGTH-1:0] read_q;
  logic                        valid_q;
  logic                        acc, ref_bad, read_bad, last;
  logic [ML-1:0]               mlen;
  logic [7:0]                  mbyte;
  assign acc = i_byte_valid && !valid_q;
  assign ref_bad = i_byte == 8'd0 || int'(i_byte) > REF_MAX_LENGTH;
  assign read_bad = i_byte == 8'd0 || int'(i_byte) > READ_MAX_LENGTH;
  assign mlen = state_q == S_REF_DATA ? ML'(ref_len_q) : ML'(read_len_q);
  assign last = int'(cnt_q) == ceil4(int'(mlen)) - 1;
  assign o_err = acc && (state_q == S_REF_LEN ? ref_bad : state_q == S_READ_LEN && read_bad);
  assign o_byte_ready = !valid_q;
  assign o_valid = valid_q;
  assign o_sequence_ref = ref_q;
  assign o_sequence_read = read_q;
  assign o_seq_ref_length = ref_len_q;
  assign o_seq_read_length = read_len_q;
  sw_base_mask #(.IW(CW), .LW(ML)) u_mask (
    .byte_i(i_byte),
    .idx_i (cnt_q),
    .len_i (mlen),
    .byte_o(mbyte)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_REF_LEN;
      ref_len_q <= '0;
      read_len_q <= '0;
      cnt_q <= '0;
      ref_q <= '0;
      read_q <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_REF_LEN: if (acc && !ref_bad) begin
          ref_len_q <= FL'(i_byte);
          ref_q <= '0;
          read_q <= '0;
          state_q <= S_READ_LEN;
        end
        S_READ_LEN: if (acc) begin
          if (read_bad) begin
            ref_len_q <= '0;
            state_q <= S_REF_LEN;
          end else begin
            read_len_q <= DL'(i_byte);
            cnt_q <= '0;
            state_q <= S_REF_DATA;
          end
        end
        S_REF_DATA: if (acc) begin
          for (int i = 0; i < REF_MAX_LENGTH / 4; i++)
            if (int'(cnt_q) == i) ref_q[2*REF_MAX_LENGTH-1-8*i -: 8] <= mbyte;
          cnt_q <= last ? '0 : cnt_q + CW'(1);
          if (last) state_q <= S_READ_DATA;
        end
        S_READ_DATA: if (acc) begin
          for (int i = 0; i < READ_MAX_LENGTH / 4; i++)
            if (int'(cnt_q) == i) read_q[2*READ_MAX_LENGTH-1-8*i -: 8] <= mbyte;
          cnt_q <= last ? '0 : cnt_q + CW'(1);
          if (last) begin
            state_q <= S_ISSUE;
            valid_q <= 1'b1;
          end
        end
        S_ISSUE: if (i_ready) begin
          state_q <= S_REF_LEN;
          valid_q <= 1'b0;
        end
        default: state_q <= S_REF_LEN;
      endcase
    end
  end
endmodule

// File: tb/tb_sw_seq_loader.sv
// tb_sw_seq_loader: directed frames with hand-packed expected job vectors
module tb_sw_seq_loader;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         i_byte_valid = 1'b0;
  logic [7:0]   i_byte = 8'd0;
  logic         i_ready = 1'b0;
  logic         o_byte_ready, o_valid, o_err;
  logic [255:0] o_sequence_ref, o_sequence_read;
  logic [7:0]   o_seq_ref_length, o_seq_read_length;
  logic [255:0] exp_ref, exp_read;
  int           total = 0;
  int           bad = 0;
  always #5 clk = ~clk;
  sw_seq_loader dut (
    .clk              (clk),
    .rst              (rst),
    .i_byte_valid     (i_byte_valid),
    .i_byte           (i_byte),
    .o_byte_ready     (o_byte_ready),
    .o_valid          (o_valid),
    .i_ready          (i_ready),
    .o_sequence_ref   (o_sequence_ref),
    .o_sequence_read  (o_sequence_read),
    .o_seq_ref_length (o_seq_ref_length),
    .o_seq_read_length(o_seq_read_length),
    .o_err            (o_err)
  );
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic put(input logic [7:0] b, input logic e);
    i_byte_valid = 1'b1;
    i_byte = b;
    #1;
    chk("byte_ready", o_byte_ready, 1'b1);
    chk("err", o_err, e);
    @(posedge clk);
    #1;
    i_byte_valid = 1'b0;
  endtask
  task automatic job(input logic [7:0] rl, input logic [7:0] dl, input logic [255:0] er, input logic [255:0] ed);
    chk("valid", o_valid, 1'b1);
    chk("ready_low", o_byte_ready, 1'b0);
    chk("ref_len", o_seq_ref_length, rl);
    chk("read_len", o_seq_read_length, dl);
    chk("ref", o_sequence_ref, er);
    chk("read", o_sequence_read, ed);
  endtask
  task automatic take();
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    i_ready = 1'b0;
    chk("valid_drop", o_valid, 1'b0);
    chk("ready_rise", o_byte_ready, 1'b1);
  endtask
  task automatic zeros(input string tag);
    chk({tag, "_ready"}, o_byte_ready, 1'b1);
    chk({tag, "_valid"}, o_valid, 1'b0);
    chk({tag, "_err"}, o_err, 1'b0);
    chk({tag, "_ref"}, o_sequence_ref, '0);
    chk({tag, "_read"}, o_sequence_read, '0);
    chk({tag, "_rlen"}, o_seq_ref_length, '0);
    chk({tag, "_dlen"}, o_seq_read_length, '0);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    zeros("reset");
    rst = 1'b1;
    put(8'd4, 1'b0);
    put(8'd4, 1'b0);
    put(8'h1B, 1'b0);
    chk("valid_early", o_valid, 1'b0);
    put(8'hE4, 1'b0);
    job(8'd4, 8'd4, {8'h1B, 248'd0}, {8'hE4, 248'd0});
    take();
    put(8'd5, 1'b0);
    put(8'd3, 1'b0);
    put(8'hFF, 1'b0);
    put(8'hFF, 1'b0);
    put(8'hFF, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
      job(8'd5, 8'd3, {8'hFF, 8'hC0, 240'd0}, {8'hFC, 248'd0});
    end
    take();
    put(8'd128, 1'b0);
    put(8'd128, 1'b0);
    exp_ref = '0;
    exp_read = '0;
    for (int k = 0; k < 32; k++) begin
      exp_ref[255-8*k -: 8] = 8'(k * 37 + 11);
      put(8'(k * 37 + 11), 1'b0);
    end
    for (int k = 0; k < 32; k++) begin
      exp_read[255-8*k -: 8] = 8'(k * 53 + 200);
      put(8'(k * 53 + 200), 1'b0);
    end
    for (int c = 0; c < 20; c++) begin
      i_byte_valid = 1'b1;
      i_byte = 8'h55;
      @(posedge clk);
      #1;
      job(8'd128, 8'd128, exp_ref, exp_read);
    end
    i_byte_valid = 1'b0;
    take();
    put(8'd0, 1'b1);
    put(8'd200, 1'b1);
    chk("rej_keep_len", o_seq_ref_length, 8'd128);
    chk("rej_keep_ref", o_sequence_ref, exp_ref);
    put(8'd3, 1'b0);
    put(8'd2, 1'b0);
    put(8'h6F, 1'b0);
    put(8'hB4, 1'b0);
    job(8'd3, 8'd2, {8'h6C, 248'd0}, {8'hB0, 248'd0});
    take();
    put(8'd8, 1'b0);
    chk("hdr_clear_ref", o_sequence_ref, '0);
    chk("hdr_clear_read", o_sequence_read, '0);
    put(8'd129, 1'b1);
    chk("discard_len", o_seq_ref_length, 8'd0);
    put(8'd2, 1'b0);
    chk("new_ref_len", o_seq_ref_length, 8'd2);
    put(8'd1, 1'b0);
    put(8'hFF, 1'b0);
    put(8'h7F, 1'b0);
    job(8'd2, 8'd1, {8'hF0, 248'd0}, {8'h40, 248'd0});
    take();
    put(8'd128, 1'b0);
    put(8'd128, 1'b0);
    for (int k = 0; k < 10; k++) put(8'hA5, 1'b0);
    chk("pre_rst_ref", o_sequence_ref[255:176], {10{8'hA5}});
    #3;
    rst = 1'b0;
    #1;
    zeros("midrst");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    zeros("post_rst");
    put(8'd4, 1'b0);
    put(8'd4, 1'b0);
    put(8'h1B, 1'b0);
    put(8'hE4, 1'b0);
    job(8'd4, 8'd4, {8'h1B, 248'd0}, {8'hE4, 248'd0});
    take();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
